// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: filtered PS/2 receiver, open-drain transmitter and keyboard init / Caps Lock LED sequencer
module ps2_host_ctrl #(
    parameter int FILTER_LEN      = 8,
    parameter int INHIBIT_CYC     = 2500,
    parameter int TIMEOUT_CYC     = 50000,
    parameter int BAT_TIMEOUT_CYC = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2clk_in,
    input  logic       ps2dat_in,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe,
    input  logic       caps_led,
    output logic       code_valid,
    output logic [7:0] code_byte,
    output logic       init_done,
    output logic       err_pulse
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int OW = $clog2(TIMEOUT_CYC + 1);
    localparam int TW = $clog2((BAT_TIMEOUT_CYC > INHIBIT_CYC ? BAT_TIMEOUT_CYC : INHIBIT_CYC) + 1);

    localparam logic [2:0] INIT_TX  = 3'd0;
    localparam logic [2:0] INIT_ACK = 3'd1;
    localparam logic [2:0] INIT_BAT = 3'd2;
    localparam logic [2:0] IDLE     = 3'd3;
    localparam logic [2:0] LED_CMD  = 3'd4;
    localparam logic [2:0] LED_ACK1 = 3'd5;
    localparam logic [2:0] LED_DATA = 3'd6;
    localparam logic [2:0] LED_ACK2 = 3'd7;

    localparam logic [1:0] PH_INH   = 2'd0;
    localparam logic [1:0] PH_START = 2'd1;
    localparam logic [1:0] PH_SHIFT = 2'd2;

    logic [1:0]    csync_q, csync_d, dsync_q, dsync_d;
    logic          flt_q, flt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [2:0]    state_q, state_d;
    logic [1:0]    ph_q, ph_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [OW-1:0] to_q, to_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [1:0]    tries_q, tries_d;
    logic          led_lat_q, led_lat_d, led_sent_q, led_sent_d;
    logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic          code_valid_q, code_valid_d;
    logic [7:0]    code_byte_q, code_byte_d;
    logic          init_done_q, init_done_d, err_q, err_d;

    logic       fall, dat, is_tx, tout, rx_good, rx_err, tx_ok, tx_err, bad, retry, rearm;
    logic [7:0] tx_byte;

    always_comb begin
        csync_d      = {csync_q[0], ps2clk_in};
        dsync_d      = {dsync_q[0], ps2dat_in};
        flt_d        = flt_q;
        fcnt_d       = (csync_q[1] == flt_q) ? '0 : fcnt_q + 1'b1;
        if (csync_q[1] != flt_q && fcnt_q == FW'(FILTER_LEN - 1)) begin
            flt_d  = csync_q[1];
            fcnt_d = '0;
        end
        fall         = flt_q & ~flt_d;
        dat          = dsync_q[1];
        state_d      = state_q;
        ph_d         = ph_q;
        tmr_d        = tmr_q;
        bit_cnt_d    = bit_cnt_q;
        sh_d         = sh_q;
        par_d        = par_q;
        tries_d      = tries_q;
        led_lat_d    = led_lat_q;
        led_sent_d   = led_sent_q;
        clk_oe_d     = clk_oe_q;
        dat_oe_d     = dat_oe_q;
        code_valid_d = 1'b0;
        code_byte_d  = code_byte_q;
        init_done_d  = init_done_q;
        rx_good      = 1'b0;
        rx_err       = 1'b0;
        tx_ok        = 1'b0;
        tx_err       = 1'b0;
        retry        = 1'b0;
        rearm        = 1'b0;
        tx_byte      = (state_q == INIT_TX) ? 8'hFF : (state_q == LED_CMD) ? 8'hED : {5'b0, led_lat_q, 2'b0};
        is_tx        = state_q == INIT_TX || state_q == LED_CMD || state_q == LED_DATA;
        // A clock fall in the same cycle as expiry counts as progress, not a timeout
        to_d         = (fall || bit_cnt_q == 4'd0) ? '0 : to_q + 1'b1;
        tout         = !fall && bit_cnt_q != 4'd0 && to_q == OW'(TIMEOUT_CYC - 1);
        if (tout) begin
            bit_cnt_d = '0;
        end else if (is_tx) begin
            if (ph_q == PH_INH) begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b0;
                tmr_d    = tmr_q + 1'b1;
                if (tmr_q == TW'(INHIBIT_CYC)) begin
                    ph_d     = PH_START;
                    dat_oe_d = 1'b1;
                end
            end else if (ph_q == PH_START) begin
                clk_oe_d  = 1'b0;
                ph_d      = PH_SHIFT;
                bit_cnt_d = 4'd1;
            end else if (fall) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q <= 4'd8) dat_oe_d = ~tx_byte[3'(bit_cnt_q - 4'd1)];
                else if (bit_cnt_q == 4'd9) dat_oe_d = ^tx_byte;
                else if (bit_cnt_q == 4'd10) dat_oe_d = 1'b0;
                else begin
                    bit_cnt_d = '0;
                    tx_ok     = !dat;
                    tx_err    = dat;
                end
            end
        end else if (fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd0) begin
                bit_cnt_d = dat ? 4'd0 : 4'd1;
                rx_err    = dat;
            end else if (bit_cnt_q <= 4'd8) sh_d = {dat, sh_q[7:1]};
            else if (bit_cnt_q == 4'd9) par_d = dat;
            else begin
                bit_cnt_d = '0;
                rx_good   = dat & (^sh_q ^ par_q);
                rx_err    = ~(dat & (^sh_q ^ par_q));
            end
        end
        bad   = tout | rx_err | tx_err;
        err_d = bad;
        case (state_q)
            INIT_TX: begin
                if (tx_ok) state_d = INIT_ACK;
                else if (bad) rearm = 1'b1;
            end
            INIT_ACK, INIT_BAT: begin
                if (state_q == INIT_BAT) tmr_d = tmr_q + 1'b1;
                if (rx_good && sh_q == ((state_q == INIT_ACK) ? 8'hFA : 8'hAA)) begin
                    state_d     = (state_q == INIT_ACK) ? INIT_BAT : IDLE;
                    tmr_d       = '0;
                    init_done_d = state_q == INIT_BAT;
                end else if (rx_good || bad || (state_q == INIT_BAT && tmr_q == TW'(BAT_TIMEOUT_CYC - 1))) begin
                    err_d   = 1'b1;
                    state_d = INIT_TX;
                    rearm   = 1'b1;
                end
            end
            IDLE: begin
                if (rx_good) begin
                    code_valid_d = 1'b1;
                    code_byte_d  = sh_q;
                end
                if (caps_led != led_sent_q && bit_cnt_q == 4'd0 && !fall) begin
                    state_d   = LED_CMD;
                    led_lat_d = caps_led;
                    tries_d   = '0;
                    rearm     = 1'b1;
                end
            end
            LED_CMD, LED_DATA: begin
                if (tx_ok) state_d = state_q + 3'd1;
                else if (bad) retry = 1'b1;
            end
            default: begin
                if (rx_good && sh_q == 8'hFA) begin
                    state_d    = (state_q == LED_ACK1) ? LED_DATA : IDLE;
                    tries_d    = '0;
                    rearm      = state_q == LED_ACK1;
                    led_sent_d = (state_q == LED_ACK2) ? led_lat_q : led_sent_q;
                end else if (rx_good || bad) retry = 1'b1;
            end
        endcase
        // 0xFE, a wrong byte and a line error all consume one of three attempts for the current byte
        if (retry) begin
            tries_d = tries_q + 2'd1;
            state_d = (state_q == LED_CMD || state_q == LED_ACK1) ? LED_CMD : LED_DATA;
            if (tries_q == 2'd2) begin
                err_d   = 1'b1;
                state_d = IDLE;
                tries_d = '0;
            end
        end
        if (rearm || retry) begin
            ph_d      = PH_INH;
            tmr_d     = '0;
            bit_cnt_d = '0;
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csync_q      <= '0;
            dsync_q      <= '0;
            flt_q        <= 1'b0;
            fcnt_q       <= '0;
            state_q      <= INIT_TX;
            ph_q         <= PH_INH;
            tmr_q        <= '0;
            to_q         <= '0;
            bit_cnt_q    <= '0;
            sh_q         <= '0;
            par_q        <= 1'b0;
            tries_q      <= '0;
            led_lat_q    <= 1'b0;
            led_sent_q   <= 1'b0;
            clk_oe_q     <= 1'b0;
            dat_oe_q     <= 1'b0;
            code_valid_q <= 1'b0;
            code_byte_q  <= '0;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            csync_q      <= csync_d;
            dsync_q      <= dsync_d;
            flt_q        <= flt_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            ph_q         <= ph_d;
            tmr_q        <= tmr_d;
            to_q         <= to_d;
            bit_cnt_q    <= bit_cnt_d;
            sh_q         <= sh_d;
            par_q        <= par_d;
            tries_q      <= tries_d;
            led_lat_q    <= led_lat_d;
            led_sent_q   <= led_sent_d;
            clk_oe_q     <= clk_oe_d;
            dat_oe_q     <= dat_oe_d;
            code_valid_q <= code_valid_d;
            code_byte_q  <= code_byte_d;
            init_done_q  <= init_done_d;
            err_q        <= err_d;
        end
    end

    assign ps2clk_oe  = clk_oe_q;
    assign ps2dat_oe  = dat_oe_q;
    assign code_valid = code_valid_q;
    assign code_byte  = code_byte_q;
    assign init_done  = init_done_q;
    assign err_pulse  = err_q;
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: PS/2 keyboard model driving the host, with a code-byte scoreboard and a frame vector table
module tb_ps2_host_ctrl;
    localparam int FL   = 8;
    localparam int INH  = 300;
    localparam int TO   = 3000;
    localparam int BAT  = 20000;
    localparam int HALF = 30;
    localparam int NV   = 9;

    typedef struct packed {
        logic [7:0] b;
        logic       bad_par;
        logic       bad_stop;
        logic       fwd;
    } vec_t;

    logic       clk = 1'b0, reset_n = 1'b0, caps_led = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
    logic       ps2clk_in, ps2dat_in, ps2clk_oe, ps2dat_oe, code_valid, init_done, err_pulse;
    logic [7:0] code_byte;
    logic [7:0] exp_q[$];
    int         n_vec = 0, n_bad = 0, err_cnt = 0, inh_run = 0, last_inh = 0;

    assign ps2clk_in = ~ps2clk_oe & dev_clk;
    assign ps2dat_in = ~ps2dat_oe & dev_dat;

    ps2_host_ctrl #(
        .FILTER_LEN(FL), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .BAT_TIMEOUT_CYC(BAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2clk_in(ps2clk_in), .ps2dat_in(ps2dat_in),
        .ps2clk_oe(ps2clk_oe), .ps2dat_oe(ps2dat_oe), .caps_led(caps_led),
        .code_valid(code_valid), .code_byte(code_byte), .init_done(init_done), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard pop, error-strobe count and inhibit-length measurement
    always @(negedge clk) begin
        if (reset_n) begin
            if (err_pulse) err_cnt++;
            if (code_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected code_valid: got %0h, expected no strobe", code_byte);
                end else check("code_byte", int'(code_byte), int'(exp_q.pop_front()));
            end
            if (ps2clk_oe && !ps2dat_oe) inh_run++;
            else begin
                if (ps2clk_oe && ps2dat_oe && inh_run > 0) last_inh = inh_run;
                inh_run = 0;
            end
        end else inh_run = 0;
    end

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_dat = f[i];
            tick(HALF);
            dev_clk = 1'b0;
            tick(HALF);
            dev_clk = 1'b1;
        end
        tick(HALF);
        dev_dat = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic host_tx(input logic [7:0] exp_b);
        logic [10:0] f;
        int w;
        f = '0;
        w = 0;
        while (!(ps2dat_oe && !ps2clk_oe) && w < 6 * INH + 2000) begin
            tick(1);
            w++;
        end
        check("tx_start", int'(ps2dat_oe && !ps2clk_oe), 1);
        check("tx_inhibit", last_inh, INH);
        tick(40);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) begin
                dev_dat = 1'b0;
                tick(HALF);
            end
            dev_clk = 1'b0;
            tick(HALF);
            dev_clk = 1'b1;
            tick(HALF);
            f[i-1] = ps2dat_in;
        end
        dev_dat = 1'b1;
        check("tx_byte", int'(f[7:0]), int'(exp_b));
        check("tx_par_stop", int'({f[9], f[8] ^ (^f[7:0])}), 3);
        check("tx_release", int'({ps2clk_oe, ps2dat_oe}), 0);
    endtask

    initial begin
        vec_t vt[NV];
        int e0;
        logic [7:0] last_fwd;
        vt[0] = '{8'h1C, 1'b0, 1'b0, 1'b1};
        vt[1] = '{8'hF0, 1'b0, 1'b0, 1'b1};
        vt[2] = '{8'h1C, 1'b0, 1'b0, 1'b1};
        vt[3] = '{8'h1C, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'h1C, 1'b0, 1'b0, 1'b1};
        vt[5] = '{8'h00, 1'b0, 1'b0, 1'b1};
        vt[6] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        vt[7] = '{8'h55, 1'b0, 1'b1, 1'b0};
        vt[8] = '{8'h80, 1'b0, 1'b0, 1'b1};
        last_fwd = 8'h00;
        tick(5);
        check("rst_oe", int'({ps2clk_oe, ps2dat_oe}), 0);
        check("rst_valid", int'(code_valid), 0);
        check("rst_byte", int'(code_byte), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_err", int'(err_pulse), 0);
        reset_n = 1'b1;
        host_tx(8'hFF);
        send_frame(8'hFA, 1'b0, 1'b0, 11);
        check("init_done_early", int'(init_done), 0);
        send_frame(8'hAA, 1'b0, 1'b0, 11);
        check("init_done", int'(init_done), 1);
        check("init_err", err_cnt, 0);
        for (int i = 0; i < NV; i++) begin
            e0 = err_cnt;
            if (vt[i].fwd) begin
                exp_q.push_back(vt[i].b);
                last_fwd = vt[i].b;
            end
            send_frame(vt[i].b, vt[i].bad_par, vt[i].bad_stop, 11);
            check("vec_pending", exp_q.size(), 0);
            check("vec_err", err_cnt - e0, vt[i].fwd ? 0 : 1);
        end
        check("code_hold", int'(code_byte), int'(last_fwd));
        e0 = err_cnt;
        send_frame(8'h29, 1'b0, 1'b0, 4);
        tick(TO / 2);
        check("timeout_early", err_cnt - e0, 0);
        tick(TO);
        check("timeout_err", err_cnt - e0, 1);
        exp_q.push_back(8'h29);
        send_frame(8'h29, 1'b0, 1'b0, 11);
        check("timeout_recover", exp_q.size(), 0);
        check("timeout_err_once", err_cnt - e0, 1);
        e0 = err_cnt;
        caps_led = 1'b1;
        host_tx(8'hED);
        send_frame(8'hFA, 1'b0, 1'b0, 11);
        host_tx(8'h04);
        send_frame(8'hFA, 1'b0, 1'b0, 11);
        caps_led = 1'b0;
        host_tx(8'hED);
        send_frame(8'hFA, 1'b0, 1'b0, 11);
        host_tx(8'h00);
        send_frame(8'hFA, 1'b0, 1'b0, 11);
        tick(2 * INH);
        check("led_quiet", int'(ps2clk_oe), 0);
        check("led_err", err_cnt - e0, 0);
        e0 = err_cnt;
        caps_led = 1'b1;
        for (int k = 0; k < 3; k++) begin
            host_tx(8'hED);
            send_frame(8'hFE, 1'b0, 1'b0, 11);
            check("fe_err", err_cnt - e0, (k == 2) ? 1 : 0);
        end
        host_tx(8'hED);
        send_frame(8'hFA, 1'b0, 1'b0, 11);
        host_tx(8'h04);
        send_frame(8'hFA, 1'b0, 1'b0, 11);
        check("fe_err_final", err_cnt - e0, 1);
        check("fe_pending", exp_q.size(), 0);
        caps_led = 1'b0;
        e0 = 0;
        while (!ps2clk_oe && e0 < 2000) begin
            tick(1);
            e0++;
        end
        check("midtx_inhibit", int'(ps2clk_oe), 1);
        tick(20);
        reset_n = 1'b0;
        tick(1);
        check("midtx_rst_oe", int'({ps2clk_oe, ps2dat_oe}), 0);
        check("midtx_rst_init", int'(init_done), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, expected completion within 90000 cycles");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_host_ctrl.md
# ps2_host_ctrl

System-clocked PS/2 host controller between the keyboard connector pins and the Z88 key-matrix update logic. Oversamples and filters the PS/2 clock/data lines, receives device frames with framing/parity/timeout checking, and forwards valid scan-code bytes as single-cycle strobes. Sequences the keyboard itself: reset command and BAT check after reset, then Caps Lock LED updates via open-drain host-to-device transmission.

## Interface

Parameters:
- FILTER_LEN, 8: consecutive equal samples needed to accept a new filtered ps2clk level
- INHIBIT_CYC, 2500: clk cycles ps2clk is held low before a transmission (100 us at 25 MHz)
- TIMEOUT_CYC, 50000: max clk cycles between device clock falls inside a frame (2 ms)
- BAT_TIMEOUT_CYC, 25000000: max clk cycles waiting for BAT result 0xAA (1 s)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- ps2clk_in  in  1  PS/2 clock pin level, asynchronous
- ps2dat_in  in  1  PS/2 data pin level, asynchronous
- ps2clk_oe  out  1  1 = drive PS/2 clock low, 0 = release
- ps2dat_oe  out  1  1 = drive PS/2 data low, 0 = release
- caps_led  in  1  requested Caps Lock LED state
- code_valid  out  1  one-cycle strobe, code_byte valid
- code_byte  out  8  received scan-code byte (E0/F0 prefixes included)
- init_done  out  1  keyboard reset sequence completed
- err_pulse  out  1  one-cycle strobe on any protocol error

## Operation

- Inputs: two-flop synchronizers. Filtered clock changes level only after FILTER_LEN equal synchronized samples. Fall event = filtered clock 1->0; data sampled (synchronized) in the same cycle.
- RX frame: start 0, 8 data LSB first, odd parity, stop 1. Bit counter 0..10, cleared after stop. Bad start/parity/stop -> err_pulse, byte discarded, counter cleared.
- Timeout: counter nonzero (RX or TX) and no fall for TIMEOUT_CYC -> err_pulse, counter cleared, FSM takes the error path of its current state.
- TX of byte B: clk_oe=1 for INHIBIT_CYC; then dat_oe=1 (start); next cycle clk_oe=0. Falls 1-8: dat_oe=~B[i-1]; fall 9: dat_oe=~parity (odd); fall 10: dat_oe=0 (stop); fall 11: sampled data must be 0 (ACK) else error.
- States: INIT_TX (send 0xFF) -> INIT_ACK (expect 0xFA) -> INIT_BAT (expect 0xAA within BAT_TIMEOUT_CYC) -> IDLE. Any wrong byte/error/timeout in INIT_* -> err_pulse, back to INIT_TX (unbounded retry). init_done=1 on entering IDLE, held until reset.
- IDLE: every good byte forwarded on code_valid/code_byte. If caps_led != last-sent LED value and RX counter is 0: LED_CMD (send 0xED) -> LED_ACK1 (expect 0xFA) -> LED_DATA (send {5'b0,caps_led_latched,2'b0}) -> LED_ACK2 (expect 0xFA) -> IDLE, last-sent updated.
- In LED_ACK*: 0xFE -> resend current byte; other byte/error -> retry; after 3 failed attempts per byte -> err_pulse, IDLE, last-sent unchanged (request re-fires). Bytes received in INIT_*/LED_ACK* never forwarded.
- caps_led latched at LED_CMD entry; changes during the sequence handled next IDLE pass.

## Timing

- Reset: ps2clk_oe=0, ps2dat_oe=0, code_valid=0, code_byte=0, init_done=0, err_pulse=0, last-sent LED=0, filters/counters 0, state INIT_TX (first inhibit starts cycle after reset release).
- Reset asserted mid-frame or mid-TX: outputs released next clk edge, frame abandoned.
- code_valid: exactly 1 cycle, cycle after the stop-bit fall; code_byte holds until next valid.
- Fall-to-sample latency: 2 sync + FILTER_LEN cycles; outputs update 1 cycle after fall event.
- Fall and timeout in same cycle: fall wins.

## Test plan

- Reset release, device model clocks FA then AA -> one 0xFF TX (ps2clk low ≥2500 cycles first), init_done=1, no code_valid.
- IDLE, device sends 0x1C then F0,1C -> code_valid three times with 0x1C, 0xF0, 0x1C.
- Frame 0x1C with bad parity -> err_pulse, no code_valid; next good 0x1C forwarded.
- Device stops after 4 bits for >50000 cycles -> err_pulse once, next full frame 0x29 received correctly.
- caps_led 0->1 -> TX 0xED, FA, TX 0x04, FA; no code_valid; toggling again -> TX 0xED, 0x00.
- LED_ACK1 answered with 0xFE three times -> 0xED sent 3 times, err_pulse, IDLE, request re-issued.
